// File: rtl/mem_stage.sv
// RV64 memory-access stage: holds one instruction from execute, runs its data
// access over a req/addr_ok/data_ok handshake and hands {pc,reg_wen,rd,wdata} to writeback.

// One byte lane of the store path: strobe and lane-shifted store byte.
module mem_byte_lane #(
  parameter int LANE = 0
) (
  input  logic        i_en,
  input  logic [2:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic [63:0] i_wdata,
  output logic        o_strb,
  output logic [7:0]  o_wbyte
);
  localparam logic [2:0] L = LANE[2:0];

  logic [2:0] w_off;
  logic [3:0] w_nbytes;
  logic       w_hit;

  assign w_off    = L - i_lane;
  assign w_nbytes = 4'd1 << i_size;
  assign w_hit    = i_en && (L >= i_lane);
  assign o_strb   = w_hit && ({1'b0, w_off} < w_nbytes);
  assign o_wbyte  = w_hit ? i_wdata[{w_off, 3'b000} +: 8] : 8'h00;
endmodule

module mem_stage #(
  parameter int EX_TO_MEM_WIDTH = 172,
  parameter int MEM_TO_WB_WIDTH = 102,
  parameter int NUM_LANES       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_to_mem_valid,
  output logic                       mem_allowin,
  input  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus,
  input  logic                       wb_allowin,
  output logic                       mem_to_wb_valid,
  output logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
  output logic [4:0]                 mem_fwd_rd,
  output logic                       data_req,
  output logic                       data_wr,
  output logic [63:0]                data_addr,
  output logic [NUM_LANES-1:0]       data_wstrb,
  output logic [63:0]                data_wdata,
  input  logic                       data_addr_ok,
  input  logic [63:0]                data_rdata,
  input  logic                       data_data_ok
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e                     r_state, w_state_nxt;
  logic                       r_mem_valid;
  logic [EX_TO_MEM_WIDTH-1:0] r_bus;
  logic [63:0]                r_result;

  logic        w_unused_jalr;
  logic [31:0] w_pc;
  logic [2:0]  w_memop;
  logic        w_reg_wen, w_memwrite, w_memread;
  logic [4:0]  w_rd;
  logic [63:0] w_alu_out, w_wdata;

  assign w_unused_jalr = r_bus[171];
  assign w_pc          = r_bus[170:139];
  assign w_memop       = r_bus[138:136];
  assign w_reg_wen     = r_bus[135];
  assign w_memwrite    = r_bus[134];
  assign w_memread     = r_bus[133];
  assign w_rd          = r_bus[132:128];
  assign w_alu_out     = r_bus[127:64];
  assign w_wdata       = r_bus[63:0];

  logic w_is_mem, w_ready_go, w_allowin, w_cap, w_cap_mem, w_resp_take;

  assign w_is_mem    = w_memread | w_memwrite;
  assign w_ready_go  = !w_is_mem || (r_state == S_DONE);
  assign w_allowin   = !r_mem_valid || (w_ready_go && wb_allowin);
  assign w_cap       = ex_to_mem_valid && w_allowin;
  assign w_cap_mem   = w_cap && (ex_to_mem_bus[134] | ex_to_mem_bus[133]);
  // A response counts in REQ only together with addr_ok; in IDLE/DONE it is ignored.
  assign w_resp_take = r_mem_valid &&
                       (((r_state == S_REQ) && data_addr_ok && data_data_ok) ||
                        ((r_state == S_WAIT) && data_data_ok));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_valid <= 1'b0;
      r_bus       <= '0;
    end else if (w_allowin) begin
      r_mem_valid <= ex_to_mem_valid;
      if (ex_to_mem_valid) r_bus <= ex_to_mem_bus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_cap_mem) w_state_nxt = S_REQ;
      S_REQ:  if (data_addr_ok) w_state_nxt = data_data_ok ? S_DONE : S_WAIT;
      S_WAIT: if (data_data_ok) w_state_nxt = S_DONE;
      S_DONE: if (wb_allowin) w_state_nxt = w_cap_mem ? S_REQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Misaligned addresses are truncated down to the access size, no trap.
  logic [2:0] w_lane;
  always_comb begin
    w_lane = 3'd0;
    case (w_memop[1:0])
      2'd0: w_lane = w_alu_out[2:0];
      2'd1: w_lane = {w_alu_out[2:1], 1'b0};
      2'd2: w_lane = {w_alu_out[2], 2'b00};
      default: w_lane = 3'd0;
    endcase
  end

  logic [63:0] w_ld_shift, w_ld_ext;
  assign w_ld_shift = data_rdata >> {w_lane, 3'b000};

  always_comb begin
    w_ld_ext = 64'd0;
    case (w_memop)
      3'd0: w_ld_ext = {{56{w_ld_shift[7]}},  w_ld_shift[7:0]};
      3'd1: w_ld_ext = {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'd2: w_ld_ext = {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
      3'd3: w_ld_ext = w_ld_shift;
      3'd4: w_ld_ext = {56'd0, w_ld_shift[7:0]};
      3'd5: w_ld_ext = {48'd0, w_ld_shift[15:0]};
      3'd6: w_ld_ext = {32'd0, w_ld_shift[31:0]};
      default: w_ld_ext = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     r_result <= 64'd0;
    else if (w_resp_take && w_memread && !w_memwrite) r_result <= w_ld_ext;
  end

  logic [NUM_LANES-1:0]      w_strb;
  logic [NUM_LANES-1:0][7:0] w_wbytes;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_byte_lane #(.LANE(g)) u_lane (
      .i_en   (w_memwrite),
      .i_lane (w_lane),
      .i_size (w_memop[1:0]),
      .i_wdata(w_wdata),
      .o_strb (w_strb[g]),
      .o_wbyte(w_wbytes[g])
    );
  end

  logic [63:0] w_result;
  assign w_result = !w_is_mem  ? w_alu_out :
                    w_memwrite ? 64'd0     : r_result;

  assign mem_allowin     = w_allowin;
  assign mem_to_wb_valid = r_mem_valid && w_ready_go;
  assign mem_to_wb_bus   = {w_pc, w_reg_wen, w_rd, w_result};
  assign mem_fwd_rd      = (r_mem_valid && w_reg_wen) ? w_rd : 5'd0;
  assign data_req        = r_mem_valid && (r_state == S_REQ);
  assign data_wr         = w_memwrite;
  assign data_addr       = w_alu_out;
  assign data_wstrb      = w_strb;
  assign data_wdata      = w_wbytes;
endmodule
